stream_arbiter_n: RTL and testbench



---
 rtl/stream_arbiter_n_pkg.sv | 20 ++
 rtl/stream_arbiter_n_if.sv | 24 ++
 rtl/stream_arbiter_n_rr_pick.sv | 29 ++
 rtl/stream_arbiter_n.sv | 130 +++++++++++++
 tb/tb_stream_arbiter_n.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/stream_arbiter_n_pkg.sv
// Shared types and helpers for the N-channel stream merge arbiter.
// Optional feature macro: STREAM_ARB_STATS_EN (per-channel pop counters).
package stream_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Width of each per-channel pop counter when statistics are built in
  localparam int STATS_W = 32;

  // ceil(log2(n)) but never narrower than one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_arbiter_n_if.sv
// Source/sink handshake bundle of the stream merge arbiter.
// master = source FIFOs + output sink side, slave = arbiter side.
interface stream_arbiter_n_if #(
  parameter int N_CH   = 5,
  parameter int DATA_W = 32
);
  logic [N_CH-1:0]        WRITE_REQ;
  logic [N_CH-1:0]        HOLD_REQ;
  logic [N_CH*DATA_W-1:0] DATA_IN;
  logic [N_CH-1:0]        READ_GRANT;
  logic                   READY_OUT;
  logic                   WRITE_OUT;
  logic [DATA_W-1:0]      DATA_OUT;

  modport master (
    output WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
    input  READ_GRANT, WRITE_OUT, DATA_OUT
  );

  modport slave (
    input  WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
    output READ_GRANT, WRITE_OUT, DATA_OUT
  );
endinterface

// File: rtl/stream_arbiter_n_rr_pick.sv
// Rotating priority finder: first requester after 'last', wrapping mod N_CH.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N_CH = 5,
  parameter int IW   = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            found
);

  // Scan last+1 .. last+N_CH; the first hit wins, 'last' itself is checked last
  always_comb begin
    int c;
    c     = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(last) + k) % N_CH;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_n.sv
// N-channel round-robin merge arbiter with burst limit and per-channel hold.
// Registered output stage; READ_GRANT is the only combinational output.
// Optional: `define STREAM_ARB_STATS_EN adds WORD_CNT per-channel pop counters.
module stream_arbiter_n
  import stream_arb_pkg::*;
#(
  parameter  int N_CH      = 5,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 16,
  localparam int CH_W      = clog2_min1(N_CH)
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST,
  stream_arbiter_n_if.slave bus,
  output logic [CH_W-1:0] GRANT_CH,
  output logic            BUSY
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [N_CH*STATS_W-1:0] WORD_CNT
`endif
);

  localparam int          BW = clog2_min1(MAX_BURST + 1);
  localparam logic [31:0] MB = 32'(MAX_BURST);

  logic [N_CH-1:0][DATA_W-1:0] din;
  assign din = bus.DATA_IN;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic                wout_q, wout_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_found;
  logic                pop;
  logic [N_CH-1:0]     read_grant;

  rr_pick #(.N_CH(N_CH), .IW(CH_W)) u_pick (
    .req   (bus.WRITE_REQ),
    .last  (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Arbitration FSM, pop strobe, burst counting and output register next-state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    wout_d  = wout_q;
    dout_d  = dout_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = pick_idx;
          burst_d = '0;
        end
      end
      GRANT: begin
        // Gated by reset so a word dropped by reset is never popped from its FIFO
        pop = bus.WRITE_REQ[grant_q] & (~wout_q | bus.READY_OUT) & ~BUS_RST;
        if (pop && burst_q != {BW{1'b1}}) burst_d = burst_q + 1'b1;
        // Hold overrides both the empty and the burst-limit release
        if (!bus.HOLD_REQ[grant_q] &&
            (!bus.WRITE_REQ[grant_q] || (MB != 0 && 32'(burst_d) >= MB))) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      wout_d = 1'b1;
      dout_d = din[grant_q];
    end else if (wout_q && bus.READY_OUT) begin
      wout_d = 1'b0;
    end
  end

  assign read_grant     = pop ? (N_CH'(1) << grant_q) : '0;
  assign bus.READ_GRANT = read_grant;
  assign bus.WRITE_OUT  = wout_q;
  assign bus.DATA_OUT   = dout_q;
  assign GRANT_CH       = grant_q;
  assign BUSY           = (state_q == GRANT);

  // State and output registers; reset leaves channel 0 first in rotation
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CH_W'(N_CH - 1);
      burst_q <= '0;
      wout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      wout_q  <= wout_d;
      dout_q  <= dout_d;
    end
  end

`ifdef STREAM_ARB_STATS_EN
  logic [N_CH-1:0][STATS_W-1:0] cnt_q, cnt_d;

  // Per-channel pop counters, free-running wrap
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_CH; i++)
      if (read_grant[i]) cnt_d[i] = cnt_q[i] + 1'b1;
  end

  // Counter registers
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign WORD_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_stream_arbiter_n.sv
// Directed bench for stream_arbiter_n: FWFT source FIFO model per channel,
// sink log of transferred words, hand-built expected word orders.
module tb_stream_arbiter_n;
  import stream_arb_pkg::*;

  localparam int N_CH = 5;
  localparam int DW   = 32;
  localparam int CW   = clog2_min1(N_CH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] grant_ch;
  logic          busy;
`ifdef STREAM_ARB_STATS_EN
  logic [N_CH*32-1:0] word_cnt;
`endif

  stream_arbiter_n_if #(.N_CH(N_CH), .DATA_W(DW)) bus ();

  stream_arbiter_n #(.N_CH(N_CH), .DATA_W(DW), .MAX_BURST(16)) dut (
    .BUS_CLK  (clk),
    .BUS_RST  (rst),
    .bus      (bus),
    .GRANT_CH (grant_ch),
    .BUSY     (busy)
`ifdef STREAM_ARB_STATS_EN
    ,
    .WORD_CNT (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0]     fq [N_CH][$];
  logic [31:0]     out_q [$];
  logic [31:0]     exp_q [$];
  logic            rst_nxt, ready_tog;
  logic [N_CH-1:0] hold_nxt;
  logic            prev_stall;
  logic [31:0]     prev_d;
  int              n_vec = 0;
  int              n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int ch, input int seq);
    return 32'hA000_0000 | (32'(ch) << 16) | 32'(seq);
  endfunction

  task automatic load(input int ch, input int n, input int start);
    for (int k = 0; k < n; k++) fq[ch].push_back(wd(ch, start + k));
  endtask

  task automatic expect_words(input int ch, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(wd(ch, first + k));
  endtask

  // One clock: drive at negedge, observe 2ns later, retire this cycle's pops
  task automatic cyc();
    @(negedge clk);
    rst          = rst_nxt;
    bus.HOLD_REQ = hold_nxt;
    if (ready_tog) bus.READY_OUT = ~bus.READY_OUT;
    for (int i = 0; i < N_CH; i++) begin
      bus.WRITE_REQ[i]          = (fq[i].size() != 0);
      bus.DATA_IN[i*DW +: DW]   = (fq[i].size() != 0) ? fq[i][0] : 32'h0;
    end
    #2;
    chk("rg_onehot", 64'($countones(bus.READ_GRANT) <= 1), 64'd1);
    if (prev_stall) begin
      chk("stall_valid", 64'(bus.WRITE_OUT), 64'd1);
      chk("stall_data", 64'(bus.DATA_OUT), 64'(prev_d));
    end
    if (bus.WRITE_OUT && bus.READY_OUT) out_q.push_back(bus.DATA_OUT);
    prev_stall = !rst && bus.WRITE_OUT && !bus.READY_OUT;
    prev_d     = bus.DATA_OUT;
    for (int i = 0; i < N_CH; i++)
      if (bus.READ_GRANT[i]) begin
        if (fq[i].size() != 0) void'(fq[i].pop_front());
        else chk($sformatf("pop_empty_ch%0d", i), 64'd1, 64'd0);
      end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst_nxt       = 1'b1;
    hold_nxt      = '0;
    ready_tog     = 1'b0;
    bus.READY_OUT = 1'b1;
    for (int i = 0; i < N_CH; i++) fq[i].delete();
    run(2);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(out_q[k]), 64'(exp_q[k]));
  endtask

  int          remain2;
  logic [31:0] head2;

  initial begin
    bus.WRITE_REQ = '0;
    bus.HOLD_REQ  = '0;
    bus.DATA_IN   = '0;
    bus.READY_OUT = 1'b1;
    prev_stall    = 1'b0;
    prev_d        = '0;

    // Reset state, then two short packets on ch0 and ch2
    do_reset();
    chk("rst_wout", 64'(bus.WRITE_OUT), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gch", 64'(grant_ch), 64'd0);
    chk("rst_rg", 64'(bus.READ_GRANT), 64'd0);
    chk("rst_dout", 64'(bus.DATA_OUT), 64'd0);
    load(0, 3, 0);
    load(2, 3, 0);
    rst_nxt = 1'b0;
    run(20);
    expect_words(0, 0, 3);
    expect_words(2, 0, 3);
    check_seq("two_ch");
    chk("two_ch_gch", 64'(grant_ch), 64'd2);
    chk("two_ch_idle", 64'(busy), 64'd0);

    // Burst limit: ch1 40 words, ch3 5 words
    do_reset();
    load(1, 40, 0);
    load(3, 5, 0);
    rst_nxt = 1'b0;
    run(70);
    expect_words(1, 0, 16);
    expect_words(3, 0, 5);
    expect_words(1, 16, 16);
    expect_words(1, 32, 8);
    check_seq("burst");

    // Hold: ch0 keeps grant across an empty gap, ch4 waits
    do_reset();
    load(0, 2, 0);
    load(4, 3, 0);
    hold_nxt = 5'b00001;
    rst_nxt  = 1'b0;
    run(8);
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_gch", 64'(grant_ch), 64'd0);
    chk("hold_cnt_a", 64'(out_q.size()), 64'd2);
    load(0, 2, 2);
    run(6);
    chk("hold_cnt_b", 64'(out_q.size()), 64'd4);
    hold_nxt = '0;
    run(15);
    expect_words(0, 0, 4);
    expect_words(4, 0, 3);
    check_seq("hold");

    // Sink stalls every other cycle during a 10-word burst
    do_reset();
    load(3, 10, 0);
    ready_tog = 1'b1;
    rst_nxt   = 1'b0;
    run(40);
    expect_words(3, 0, 10);
    check_seq("stall");
    ready_tog     = 1'b0;
    bus.READY_OUT = 1'b1;

    // Reset in the middle of a ch2 burst
    do_reset();
    load(2, 10, 0);
    rst_nxt = 1'b0;
    run(5);
    rst_nxt = 1'b1;
    cyc();
    remain2 = fq[2].size();
    head2   = (remain2 != 0) ? fq[2][0] : 32'h0;
    chk("mid_rst_popped", 64'(remain2 < 10 && remain2 > 0), 64'd1);
    rst_nxt = 1'b0;
    load(0, 2, 0);
    out_q.delete();
    cyc();
    chk("mid_rst_wout", 64'(bus.WRITE_OUT), 64'd0);
    chk("mid_rst_rg", 64'(bus.READ_GRANT), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dout", 64'(bus.DATA_OUT), 64'd0);
    run(30);
    chk("mid_rst_cnt", 64'(out_q.size()), 64'(2 + remain2));
    if (out_q.size() >= 3) begin
      chk("mid_rst_first0", 64'(out_q[0]), 64'(wd(0, 0)));
      chk("mid_rst_first1", 64'(out_q[1]), 64'(wd(0, 1)));
      chk("mid_rst_ch2_resume", 64'(out_q[2]), 64'(head2));
    end else begin
      chk("mid_rst_short", 64'(out_q.size()), 64'd3);
    end

`ifdef STREAM_ARB_STATS_EN
    // Pop statistics
    do_reset();
    for (int i = 0; i < N_CH; i++)
      chk($sformatf("stats_rst_ch%0d", i), 64'(word_cnt[i*32 +: 32]), 64'd0);
    load(1, 7, 0);
    load(4, 3, 0);
    rst_nxt = 1'b0;
    run(30);
    chk("stats_ch0", 64'(word_cnt[0*32 +: 32]), 64'd0);
    chk("stats_ch1", 64'(word_cnt[1*32 +: 32]), 64'd7);
    chk("stats_ch2", 64'(word_cnt[2*32 +: 32]), 64'd0);
    chk("stats_ch3", 64'(word_cnt[3*32 +: 32]), 64'd0);
    chk("stats_ch4", 64'(word_cnt[4*32 +: 32]), 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
